// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Holds the access-size enum, FSM state encoding and latency limit.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT = 2'd0;
    localparam state_t ST_IDLE = 2'd1;
    localparam state_t ST_WAIT = 2'd2;

    localparam int LATENCY_MAX = 8;

    // Number of bytes touched by an access of the given size.
    function automatic int unsigned size_bytes(input size_e s);
        return 32'd1 << s;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load lane alignment: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends. Ports: word/lane/size/is_unsigned in, data out.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]              word,
    input  logic [$clog2(XLEN/8)-1:0]    lane,
    input  size_e                        size,
    input  logic                         is_unsigned,
    output logic [XLEN-1:0]              data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] left;
    int unsigned     bits;
    int unsigned     pad;

    // Push the field to the top, then shift back down logically or
    // arithmetically; a zero pad means a full-width access.
    always_comb begin
        shifted = word >> {lane, 3'b000};
        bits    = size_bytes(size) * 8;
        pad     = (bits >= XLEN) ? 0 : (XLEN - bits);
        left    = shifted << pad;
        if (is_unsigned && pad != 0) begin
            data = left >> pad;
        end else begin
            data = $unsigned($signed(left) >>> pad);
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data memory controller with zero-clear sweep after reset.
// Ports: clk/rst, req_* handshake in, rsp_* response out, init_busy.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            init_busy
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CNTW = $clog2(LATENCY + 1);

    logic [XLEN-1:0] mem [DEPTH];

    state_t          state;
    logic [IDXW-1:0] sweep;
    logic [CNTW-1:0] cnt;

    logic [XLEN-1:0] pend_word;
    logic [OFFW-1:0] pend_lane;
    size_e           pend_size;
    logic            pend_uns;
    logic            pend_err;

    logic            rsp_v_q;
    logic            rsp_e_q;
    logic [XLEN-1:0] rsp_d_q;

    size_e           sz;
    logic [OFFW-1:0] lane;
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] word_no;
    logic [OFFW-1:0] amask;
    logic [31:0]     bmask;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wshift;
    logic            misal;
    logic            oor;
    logic            illegal;
    logic            req_err;
    logic            accept;

    logic [XLEN-1:0] al_word;
    logic [OFFW-1:0] al_lane;
    size_e           al_size;
    logic            al_uns;
    logic [XLEN-1:0] al_data;

    always_comb begin
        sz      = size_e'(req_size);
        lane    = req_addr[OFFW-1:0];
        idx     = req_addr[OFFW +: IDXW];
        word_no = req_addr >> OFFW;
        amask   = OFFW'(size_bytes(sz) - 32'd1);
        misal   = |(lane & amask);
        oor     = word_no >= XLEN'(DEPTH);
        illegal = (XLEN == 32) && (sz == SZ_D);
        req_err = misal || oor || illegal;
        accept  = req_valid && req_ready;
        bmask   = (32'd1 << size_bytes(sz)) - 32'd1;
        be      = NB'(bmask << lane);
        wshift  = req_wdata << {lane, 3'b000};
    end

    // In WAIT the aligner works on the captured word; otherwise it
    // works on the live request so a one-cycle load can respond.
    always_comb begin
        if (state == ST_WAIT) begin
            al_word = pend_word;
            al_lane = pend_lane;
            al_size = pend_size;
            al_uns  = pend_uns;
        end else begin
            al_word = mem[idx];
            al_lane = lane;
            al_size = sz;
            al_uns  = req_unsigned;
        end
    end

    dmem_lane_align #(
        .XLEN(XLEN)
    ) u_align (
        .word        (al_word),
        .lane        (al_lane),
        .size        (al_size),
        .is_unsigned (al_uns),
        .data        (al_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[sweep] <= '0;
            end else if (accept && req_we && !req_err) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[b]) begin
                        mem[idx][b*8 +: 8] <= wshift[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep     <= '0;
            cnt       <= '0;
            pend_word <= '0;
            pend_lane <= '0;
            pend_size <= SZ_B;
            pend_uns  <= 1'b0;
            pend_err  <= 1'b0;
            rsp_v_q   <= 1'b0;
            rsp_e_q   <= 1'b0;
            rsp_d_q   <= '0;
        end else begin
            rsp_v_q <= 1'b0;
            rsp_e_q <= 1'b0;
            rsp_d_q <= '0;
            unique case (state)
                ST_INIT: begin
                    sweep <= sweep + 1'b1;
                    if (sweep == IDXW'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (req_we || LATENCY == 1) begin
                            rsp_v_q <= 1'b1;
                            rsp_e_q <= req_err;
                            rsp_d_q <= (req_we || req_err) ? '0 : al_data;
                        end else begin
                            state     <= ST_WAIT;
                            cnt       <= CNTW'(1);
                            pend_word <= mem[idx];
                            pend_lane <= lane;
                            pend_size <= sz;
                            pend_uns  <= req_unsigned;
                            pend_err  <= req_err;
                        end
                    end
                end
                ST_WAIT: begin
                    // Accepting edge counted as 1; respond on edge LATENCY.
                    if (cnt == CNTW'(LATENCY - 1)) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        rsp_v_q <= 1'b1;
                        rsp_e_q <= pend_err;
                        rsp_d_q <= pend_err ? '0 : al_data;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Gating with rst drops any response still in flight during reset.
    assign req_ready = (state == ST_IDLE) && !rst;
    assign init_busy = (state == ST_INIT) || rst;
    assign rsp_valid = rsp_v_q && !rst;
    assign rsp_err   = rsp_e_q && !rst;
    assign rsp_rdata = rst ? '0 : rsp_d_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table plus reset and
// back-to-back corner sequences.
module tb_dmem_ctrl;

    localparam int XLEN    = 64;
    localparam int DEPTH   = 16;
    localparam int LATENCY = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;
    logic            init_busy;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_busy    (init_busy)
    );

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [63:0] addr,
                                input logic [1:0] size, input logic uns,
                                input logic [63:0] wdata,
                                input logic [63:0] exp_data,
                                input logic exp_err);
        vec_t v;
        v.we       = we;
        v.addr     = addr;
        v.size     = size;
        v.uns      = uns;
        v.wdata    = wdata;
        v.exp_data = exp_data;
        v.exp_err  = exp_err;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge where rsp_valid is seen.
    task automatic do_req(input logic we, input logic [63:0] addr,
                          input logic [1:0] size, input logic uns,
                          input logic [63:0] wdata,
                          output logic [63:0] data, output logic err,
                          output int lat, output int lowrdy);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat    = 0;
        lowrdy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rsp_valid && !req_ready) lowrdy++;
        end while (!rsp_valid && lat < 20);
        data = rsp_rdata;
        err  = rsp_err;
    endtask

    task automatic count_init(output int n);
        n = 0;
        while (init_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic        e;
        int          lat;
        int          low;
        int          n;
        logic        seen;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = '0;

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_init_busy", 64'(init_busy), 64'd1);

        rst = 1'b0;
        count_init(n);
        chk("init_cycles", 64'(n), 64'd16);
        chk("ready_after_init", 64'(req_ready), 64'd1);

        vecs.push_back(mk(0, 64'h40, 2'b11, 0, 0, 64'h0, 0));
        vecs.push_back(mk(1, 64'h8, 2'b11, 0,
                          64'h1122_3344_5566_7788, 64'h0, 0));
        vecs.push_back(mk(1, 64'hB, 2'b00, 0, 64'hAB, 64'h0, 0));
        vecs.push_back(mk(0, 64'h8, 2'b11, 0, 0,
                          64'h1122_3344_AB66_7788, 0));
        vecs.push_back(mk(0, 64'hB, 2'b00, 0, 0,
                          64'hFFFF_FFFF_FFFF_FFAB, 0));
        vecs.push_back(mk(0, 64'hB, 2'b00, 1, 0, 64'hAB, 0));
        vecs.push_back(mk(0, 64'h9, 2'b01, 0, 0, 64'h0, 1));
        vecs.push_back(mk(1, 64'h0, 2'b11, 0,
                          64'hCAFE_F00D_DEAD_BEEF, 64'h0, 0));
        vecs.push_back(mk(1, 64'h2000, 2'b11, 0,
                          64'h5555_5555_5555_5555, 64'h0, 1));
        vecs.push_back(mk(0, 64'h0, 2'b11, 0, 0,
                          64'hCAFE_F00D_DEAD_BEEF, 0));
        vecs.push_back(mk(0, 64'hA, 2'b01, 0, 0,
                          64'hFFFF_FFFF_FFFF_AB66, 0));
        vecs.push_back(mk(0, 64'hC, 2'b10, 1, 0, 64'h1122_3344, 0));
        vecs.push_back(mk(0, 64'h8, 2'b10, 0, 0,
                          64'hFFFF_FFFF_AB66_7788, 0));
        vecs.push_back(mk(1, 64'hE, 2'b01, 0,
                          64'h1234_0000_BEEF, 64'h0, 0));
        vecs.push_back(mk(0, 64'h8, 2'b11, 0, 0,
                          64'hBEEF_3344_AB66_7788, 0));
        vecs.push_back(mk(1, 64'h6, 2'b10, 0,
                          64'hFFFF_FFFF, 64'h0, 1));
        vecs.push_back(mk(0, 64'h0, 2'b11, 0, 0,
                          64'hCAFE_F00D_DEAD_BEEF, 0));
        vecs.push_back(mk(1, 64'h78, 2'b11, 0,
                          64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 0));
        vecs.push_back(mk(0, 64'h78, 2'b11, 0, 0,
                          64'hA5A5_A5A5_A5A5_A5A5, 0));
        vecs.push_back(mk(0, 64'h80, 2'b11, 0, 0, 64'h0, 1));
        vecs.push_back(mk(0, 64'h4, 2'b11, 0, 0, 64'h0, 1));
        vecs.push_back(mk(0, 64'hE, 2'b01, 1, 0, 64'hBEEF, 0));
        vecs.push_back(mk(0, 64'hE, 2'b01, 0, 0,
                          64'hFFFF_FFFF_FFFF_BEEF, 0));
        vecs.push_back(mk(0, 64'h8, 2'b11, 1, 0,
                          64'hBEEF_3344_AB66_7788, 0));

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns,
                   vecs[i].wdata, d, e, lat, low);
            chk($sformatf("v%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("v%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_lat", i), 64'(lat),
                vecs[i].we ? 64'd1 : 64'(LATENCY));
            chk($sformatf("v%0d_rdy_low", i), 64'(low),
                vecs[i].we ? 64'd0 : 64'(LATENCY - 1));
            chk($sformatf("v%0d_ready_at_rsp", i), 64'(req_ready), 64'd1);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 64'(rsp_valid), 64'd0);
        end

        // Back-to-back loads: second accepted in first's rsp_valid cycle.
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 64'h0;
        req_size     = 2'b11;
        req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        chk("b2b_first_lat", 64'(lat), 64'(LATENCY));
        chk("b2b_first_data", rsp_rdata, 64'hCAFE_F00D_DEAD_BEEF);
        chk("b2b_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = 64'h8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        chk("b2b_second_lat", 64'(lat), 64'(LATENCY));
        chk("b2b_second_data", rsp_rdata, 64'hBEEF_3344_AB66_7788);
        @(negedge clk);

        // Reset while a load sits in WAIT.
        seen         = 1'b0;
        req_valid    = 1'b1;
        req_addr     = 64'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("wait_ready_low", 64'(req_ready), 64'd0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        rst = 1'b0;
        n = 0;
        while (init_busy && n < 100) begin
            seen = seen | rsp_valid;
            n++;
            @(negedge clk);
        end
        chk("wait_rst_init_cycles", 64'(n), 64'd16);
        chk("wait_rst_no_rsp", 64'(seen), 64'd0);
        do_req(0, 64'h0, 2'b11, 0, 0, d, e, lat, low);
        chk("wait_rst_word0", d, 64'h0);
        chk("wait_rst_word0_lat", 64'(lat), 64'(LATENCY));
        @(negedge clk);
        do_req(0, 64'h8, 2'b11, 0, 0, d, e, lat, low);
        chk("wait_rst_word1", d, 64'h0);
        @(negedge clk);
        do_req(0, 64'h78, 2'b11, 0, 0, d, e, lat, low);
        chk("wait_rst_word15", d, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
